// File: rtl/deck_shuffle_dealer_if.sv
// Game-side and deck-RAM-side signals of deck_shuffle_dealer.
// The dealer takes the slave modport; the game FSM and RAM side take master.
interface deck_shuffle_dealer_if #(
   parameter int CARD_W = 8,
   parameter int ADDR_W = 6
);
   // Deal handshake: get_card is a level request. card_ready rises while
   // card_out is valid and stays high until get_card drops; the drop
   // releases the card, so each low->high->low of get_card deals exactly one.
   logic              get_card;
   logic              reshuffle;
   logic [CARD_W-1:0] card_out;
   logic              card_ready;
   logic              game_ready;
   logic              deck_empty;
   logic [ADDR_W:0]   cards_left;

   logic [CARD_W-1:0] mem_rdata;
   logic [ADDR_W-1:0] mem_address;
   logic [CARD_W-1:0] mem_wdata;
   logic              mem_write_enable;

   modport master (
      output get_card, reshuffle, mem_rdata,
      input  card_out, card_ready, game_ready, deck_empty, cards_left,
      input  mem_address, mem_wdata, mem_write_enable
   );

   modport slave (
      input  get_card, reshuffle, mem_rdata,
      output card_out, card_ready, game_ready, deck_empty, cards_left,
      output mem_address, mem_wdata, mem_write_enable
   );
endinterface

// File: rtl/deck_shuffle_dealer.sv
// Deck controller: optional identity fill, in-place Fisher-Yates shuffle, level-handshake deal.
// Build option: define DECK_SHUFFLE_DEALER_FILL_EN to include the FILL state.
module deck_shuffle_dealer #(
   parameter int CARD_W    = 8,
   parameter int DECK_SIZE = 52,
   parameter int ADDR_W    = 6,
   parameter int PASSES    = 7
) (
   input  logic                 clock,
   input  logic                 reset,
   deck_shuffle_dealer_if.slave bus,
   output logic [3:0]           fsm_state
);

   typedef enum logic [3:0] {
      FILL  = 4'd0,
      DRAW  = 4'd1,
      RD_I  = 4'd2,
      RD_J  = 4'd3,
      WR_I  = 4'd4,
      WR_J  = 4'd5,
      NEXT  = 4'd6,
      READY = 4'd7,
      FETCH = 4'd8,
      HOLD  = 4'd9,
      EMPTY = 4'd10
   } state_t;

   localparam int PASS_W = $clog2(PASSES + 1);

   // Smallest all-ones mask covering the top index, so draws are rejected at most ~half the time.
   function automatic logic [ADDR_W-1:0] first_mask();
      logic [ADDR_W-1:0] m;
      m = '1;
      for (int b = 0; b < ADDR_W; b++) begin
         if (ADDR_W'(DECK_SIZE - 1) <= (m >> 1)) m = m >> 1;
      end
      return m;
   endfunction

   localparam logic [ADDR_W-1:0] MASK0  = first_mask();
   localparam logic [ADDR_W-1:0] LAST_I = ADDR_W'(DECK_SIZE - 1);
   localparam logic [ADDR_W:0]   DECK_N = (ADDR_W+1)'(DECK_SIZE);

`ifdef DECK_SHUFFLE_DEALER_FILL_EN
   localparam state_t START = FILL;
`else
   localparam state_t START = DRAW;
`endif

   state_t            state;
   logic [15:0]       lfsr;
   logic [15:0]       seed;
   logic [ADDR_W-1:0] i;
   logic [ADDR_W-1:0] j;
   logic [ADDR_W-1:0] mask;
   logic [PASS_W-1:0] pass;
   logic [ADDR_W:0]   deal_ptr;
   logic [CARD_W-1:0] card_i;
   logic [CARD_W-1:0] card_out;
   logic              card_ready;
   logic              game_ready;
   logic              deck_empty;
`ifdef DECK_SHUFFLE_DEALER_FILL_EN
   logic [ADDR_W-1:0] fill_k;
`endif

   logic [15:0]       lfsr_step;
   logic [15:0]       reseed;
   logic [ADDR_W-1:0] draw;
   logic [ADDR_W-1:0] i_dec;
   logic [PASS_W-1:0] pass_inc;
   logic [ADDR_W:0]   ptr_inc;

   assign lfsr_step = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
   assign reseed    = seed ^ lfsr;
   assign draw      = lfsr[ADDR_W-1:0] & mask;
   assign i_dec     = i - ADDR_W'(1);
   assign pass_inc  = pass + PASS_W'(1);
   assign ptr_inc   = deal_ptr + (ADDR_W+1)'(1);

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= START;
         lfsr       <= 16'hACE1;
         seed       <= 16'h0000;
         i          <= LAST_I;
         j          <= '0;
         mask       <= MASK0;
         pass       <= '0;
         deal_ptr   <= '0;
         card_i     <= '0;
         card_out   <= '0;
         card_ready <= 1'b0;
         game_ready <= 1'b0;
         deck_empty <= 1'b0;
`ifdef DECK_SHUFFLE_DEALER_FILL_EN
         fill_k     <= '0;
`endif
      end else begin
         seed <= seed + 16'd1;
         case (state)
`ifdef DECK_SHUFFLE_DEALER_FILL_EN
            FILL: begin
               if (fill_k == LAST_I) begin
                  i     <= LAST_I;
                  mask  <= MASK0;
                  state <= DRAW;
               end else begin
                  fill_k <= fill_k + ADDR_W'(1);
               end
            end
`endif
            DRAW: begin
               lfsr <= lfsr_step;
               if (draw <= i) begin
                  j     <= draw;
                  state <= RD_I;
               end
            end
            RD_I: state <= RD_J;
            RD_J: begin
               card_i <= bus.mem_rdata;
               state  <= WR_I;
            end
            WR_I: state <= WR_J;
            WR_J: state <= NEXT;
            NEXT: begin
               if (i_dec == '0) begin
                  pass <= pass_inc;
                  if (pass_inc == PASS_W'(PASSES)) begin
                     deal_ptr   <= '0;
                     game_ready <= 1'b1;
                     state      <= READY;
                  end else begin
                     i     <= LAST_I;
                     mask  <= MASK0;
                     state <= DRAW;
                  end
               end else begin
                  i <= i_dec;
                  if (i_dec <= (mask >> 1)) mask <= mask >> 1;
                  state <= DRAW;
               end
            end
            READY, EMPTY: begin
               if (bus.reshuffle) begin
                  // A zero LFSR would lock up, so fold in the seed and never load zero.
                  lfsr       <= (reseed == 16'h0000) ? 16'h0001 : reseed;
                  pass       <= '0;
                  deal_ptr   <= '0;
                  deck_empty <= 1'b0;
                  game_ready <= 1'b0;
                  i          <= LAST_I;
                  mask       <= MASK0;
`ifdef DECK_SHUFFLE_DEALER_FILL_EN
                  fill_k     <= '0;
`endif
                  state      <= START;
               end else if (state == READY && bus.get_card) begin
                  state <= FETCH;
               end
            end
            FETCH: begin
               card_out   <= bus.mem_rdata;
               card_ready <= 1'b1;
               state      <= HOLD;
            end
            HOLD: begin
               if (!bus.get_card) begin
                  card_ready <= 1'b0;
                  deal_ptr   <= ptr_inc;
                  if (ptr_inc == DECK_N) begin
                     deck_empty <= 1'b1;
                     game_ready <= 1'b0;
                     state      <= EMPTY;
                  end else begin
                     state <= READY;
                  end
               end
            end
            default: state <= START;
         endcase
      end
   end

   // RAM port decoded from the registered state; read data returns one cycle later.
   always_comb begin
      bus.mem_address      = '0;
      bus.mem_wdata        = '0;
      bus.mem_write_enable = 1'b0;
      case (state)
`ifdef DECK_SHUFFLE_DEALER_FILL_EN
         FILL: begin
            bus.mem_address      = fill_k;
            bus.mem_wdata        = CARD_W'(fill_k);
            bus.mem_write_enable = !reset;
         end
`endif
         RD_I: bus.mem_address = i;
         RD_J: bus.mem_address = j;
         WR_I: begin
            bus.mem_address      = i;
            bus.mem_wdata        = bus.mem_rdata;
            bus.mem_write_enable = 1'b1;
         end
         WR_J: begin
            bus.mem_address      = j;
            bus.mem_wdata        = card_i;
            bus.mem_write_enable = 1'b1;
         end
         READY, FETCH, HOLD: bus.mem_address = deal_ptr[ADDR_W-1:0];
         default: bus.mem_address = '0;
      endcase
   end

   assign bus.card_out   = card_out;
   assign bus.card_ready = card_ready;
   assign bus.game_ready = game_ready;
   assign bus.deck_empty = deck_empty;
   assign bus.cards_left = DECK_N - deal_ptr;
   assign fsm_state      = state;

endmodule

// File: tb/tb_deck_shuffle_dealer.sv
// Directed bench: a 4-card instance against a hand-computed shuffle, a 52-card instance for dealing.
// Follows the DECK_SHUFFLE_DEALER_FILL_EN build option of the design.
module tb_deck_shuffle_dealer;

`ifdef DECK_SHUFFLE_DEALER_FILL_EN
   localparam bit FILL_ON = 1'b1;
`else
   localparam bit FILL_ON = 1'b0;
`endif

   localparam logic [3:0] S_FILL  = 4'd0;
   localparam logic [3:0] S_DRAW  = 4'd1;
   localparam logic [3:0] S_FETCH = 4'd8;
   localparam logic [3:0] S_READY = 4'd7;
   localparam logic [3:0] S_HOLD  = 4'd9;
   localparam logic [3:0] S_EMPTY = 4'd10;
   localparam logic [3:0] S_START = FILL_ON ? S_FILL : S_DRAW;
   localparam logic [7:0] B_BASE  = FILL_ON ? 8'h00 : 8'hA0;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset_a;
   logic reset_b;
   always #5 clock = ~clock;

   deck_shuffle_dealer_if #(.CARD_W(8), .ADDR_W(6)) bus_a ();
   deck_shuffle_dealer_if #(.CARD_W(8), .ADDR_W(2)) bus_b ();
   logic [3:0] state_a;
   logic [3:0] state_b;

   deck_shuffle_dealer #(.CARD_W(8), .DECK_SIZE(52), .ADDR_W(6), .PASSES(7)) dut_a (
      .clock(clock), .reset(reset_a), .bus(bus_a), .fsm_state(state_a));

   deck_shuffle_dealer #(.CARD_W(8), .DECK_SIZE(4), .ADDR_W(2), .PASSES(1)) dut_b (
      .clock(clock), .reset(reset_b), .bus(bus_b), .fsm_state(state_b));

   // ---------------- RAM models with a preload port ----------------
   logic       load_en = 1'b0;
   logic [5:0] load_addr = 6'd0;
   logic [7:0] ram_a [64];
   logic [7:0] ram_b [4];

   always @(posedge clock) begin
      if (load_en)
         ram_a[load_addr] <= FILL_ON ? 8'hEE : ((load_addr < 6'd52) ? {2'b00, load_addr} : 8'hFF);
      else if (bus_a.mem_write_enable)
         ram_a[bus_a.mem_address] <= bus_a.mem_wdata;
      bus_a.mem_rdata <= ram_a[bus_a.mem_address];
   end

   always @(posedge clock) begin
      if (load_en && load_addr < 6'd4)
         ram_b[load_addr[1:0]] <= 8'hA0 + {2'b00, load_addr};
      else if (bus_b.mem_write_enable)
         ram_b[bus_b.mem_address] <= bus_b.mem_wdata;
      bus_b.mem_rdata <= ram_b[bus_b.mem_address];
   end

   // ---------------- scoreboard ----------------
   logic [9:0] exp_q [$];
   logic [9:0] wr_q [$];
   always @(posedge clock)
      if (!reset_b && bus_b.mem_write_enable) wr_q.push_back({bus_b.mem_address, bus_b.mem_wdata});

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   // ---------------- driver tasks ----------------
   logic sel = 1'b0;
   wire       w_card_ready = sel ? bus_b.card_ready : bus_a.card_ready;
   wire [7:0] w_card_out   = sel ? bus_b.card_out   : bus_a.card_out;
   wire       w_game_ready = sel ? bus_b.game_ready : bus_a.game_ready;

   task automatic set_get(input logic v);
      if (sel) bus_b.get_card = v;
      else     bus_a.get_card = v;
   endtask

   task automatic wait_ready(input string tag, input int budget);
      int cyc;
      cyc = 0;
      while (!w_game_ready && cyc < budget) begin
         @(negedge clock);
         cyc++;
      end
      check(tag, w_game_ready, 1);
   endtask

   task automatic deal(output logic [7:0] card, output int lat);
      lat = 0;
      set_get(1'b1);
      do begin
         @(negedge clock);
         lat++;
      end while (!w_card_ready && lat < 12);
      card = w_card_out;
      set_get(1'b0);
      @(negedge clock);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   int         sw_addr [6] = '{3, 1, 2, 0, 1, 0};
   int         sw_off  [6] = '{1, 3, 0, 2, 2, 3};
   int         deal_off [4] = '{3, 2, 0, 1};
   logic [63:0] seen;
   logic [7:0] order1 [52];
   logic [7:0] card;
   int         lat;
   int         cyc;
   int         ndiff;

   initial begin
      reset_a = 1'b1;
      reset_b = 1'b1;
      bus_a.get_card = 1'b0;
      bus_a.reshuffle = 1'b0;
      bus_b.get_card = 1'b0;
      bus_b.reshuffle = 1'b0;
      for (int k = 0; k < 64; k++) begin
         @(negedge clock);
         load_en = 1'b1;
         load_addr = k[5:0];
      end
      @(negedge clock);
      load_en = 1'b0;

      // reset values
      check("a_rst_card_ready", bus_a.card_ready, 0);
      check("a_rst_card_out", bus_a.card_out, 0);
      check("a_rst_game_ready", bus_a.game_ready, 0);
      check("a_rst_deck_empty", bus_a.deck_empty, 0);
      check("a_rst_cards_left", bus_a.cards_left, 52);
      check("a_rst_write_enable", bus_a.mem_write_enable, 0);
      check("a_rst_state", state_a, S_START);
      check("b_rst_cards_left", bus_b.cards_left, 4);
      check("b_rst_state", state_b, S_START);

      // 4-card deck: reshuffle held during the shuffle must be ignored
      if (FILL_ON) for (int k = 0; k < 4; k++) exp_q.push_back({k[1:0], k[7:0]});
      for (int k = 0; k < 6; k++) exp_q.push_back({sw_addr[k][1:0], B_BASE + sw_off[k][7:0]});
      sel = 1'b1;
      bus_b.reshuffle = 1'b1;
      reset_b = 1'b0;
      cyc = 0;
      while (!bus_b.game_ready && cyc < 200) begin
         @(negedge clock);
         cyc++;
         if (cyc == 6) bus_b.reshuffle = 1'b0;
      end
      check("b_shuffle_cycles", cyc, FILL_ON ? 22 : 18);
      check("b_state_ready", state_b, S_READY);
      check("b_write_count", wr_q.size(), exp_q.size());
      for (int k = 0; k < exp_q.size(); k++)
         if (k < wr_q.size()) check("b_write", wr_q[k], exp_q[k]);
      for (int k = 0; k < 4; k++) begin
         check("b_cards_left", bus_b.cards_left, 4 - k);
         deal(card, lat);
         check("b_deal_latency", lat, 2);
         check("b_card", card, B_BASE + deal_off[k][7:0]);
         check("b_card_released", bus_b.card_ready, 0);
      end
      check("b_deck_empty", bus_b.deck_empty, 1);
      check("b_game_ready_empty", bus_b.game_ready, 0);
      check("b_cards_left_zero", bus_b.cards_left, 0);
      check("b_state_empty", state_b, S_EMPTY);

      // 52-card deck: shuffle, handshake with get_card held 10 cycles
      sel = 1'b0;
      reset_a = 1'b0;
      wait_ready("a_shuffle_done", 30000);
      check("a_state_ready", state_a, S_READY);
      check("a_cards_left_full", bus_a.cards_left, 52);
      check("a_not_empty", bus_a.deck_empty, 0);
      set_get(1'b1);
      @(negedge clock);
      check("a_fetch_not_ready", bus_a.card_ready, 0);
      check("a_state_fetch", state_a, S_FETCH);
      @(negedge clock);
      check("a_hold_ready", bus_a.card_ready, 1);
      check("a_state_hold", state_a, S_HOLD);
      card = bus_a.card_out;
      repeat (8) @(negedge clock);
      check("a_hold_still_ready", bus_a.card_ready, 1);
      check("a_hold_no_advance", bus_a.cards_left, 52);
      set_get(1'b0);
      @(negedge clock);
      check("a_release_ready", bus_a.card_ready, 0);
      check("a_release_advance", bus_a.cards_left, 51);
      check("a_release_state", state_a, S_READY);
      seen = '0;
      check("a_card_unique", (card < 8'd52) && !seen[card[5:0]], 1);
      seen[card[5:0]] = 1'b1;
      order1[0] = card;
      for (int k = 1; k < 52; k++) begin
         check("a_cards_left", bus_a.cards_left, 52 - k);
         deal(card, lat);
         check("a_deal_latency", lat, 2);
         check("a_card_unique", (card < 8'd52) && !seen[card[5:0]], 1);
         seen[card[5:0]] = 1'b1;
         order1[k] = card;
      end
      check("a_deck_empty", bus_a.deck_empty, 1);
      check("a_game_ready_empty", bus_a.game_ready, 0);
      check("a_cards_left_zero", bus_a.cards_left, 0);
      check("a_state_empty", state_a, S_EMPTY);

      // get_card in EMPTY is ignored
      set_get(1'b1);
      repeat (3) @(negedge clock);
      check("a_empty_no_card", bus_a.card_ready, 0);
      check("a_empty_stays", state_a, S_EMPTY);
      set_get(1'b0);

      // reshuffle in EMPTY restarts with a new permutation
      bus_a.reshuffle = 1'b1;
      @(negedge clock);
      bus_a.reshuffle = 1'b0;
      check("a_reshuffle_empty_clear", bus_a.deck_empty, 0);
      check("a_reshuffle_cards_left", bus_a.cards_left, 52);
      check("a_reshuffle_state", state_a, S_START);
      wait_ready("a_reshuffle_done", 30000);
      seen = '0;
      ndiff = 0;
      for (int k = 0; k < 52; k++) begin
         deal(card, lat);
         check("a2_card_unique", (card < 8'd52) && !seen[card[5:0]], 1);
         seen[card[5:0]] = 1'b1;
         if (card != order1[k]) ndiff++;
      end
      check("a2_new_permutation", ndiff != 0, 1);
      check("a2_deck_empty", bus_a.deck_empty, 1);

      // reset while holding the fourth card
      bus_a.reshuffle = 1'b1;
      @(negedge clock);
      bus_a.reshuffle = 1'b0;
      wait_ready("a_third_shuffle_done", 30000);
      for (int k = 0; k < 3; k++) deal(card, lat);
      set_get(1'b1);
      repeat (2) @(negedge clock);
      check("a_mid_state_hold", state_a, S_HOLD);
      check("a_mid_cards_left", bus_a.cards_left, 49);
      reset_a = 1'b1;
      set_get(1'b0);
      @(negedge clock);
      check("a_mid_rst_card_ready", bus_a.card_ready, 0);
      check("a_mid_rst_card_out", bus_a.card_out, 0);
      check("a_mid_rst_cards_left", bus_a.cards_left, 52);
      check("a_mid_rst_game_ready", bus_a.game_ready, 0);
      check("a_mid_rst_state", state_a, S_START);
      reset_a = 1'b0;
      @(negedge clock);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
